// File: rtl/fm_hop_sequencer.sv
// Wishbone master that steps the FM generator carrier centre through a programmable
// table of increments, dwelling a fixed number of cycles per hop.
module fm_hop_sequencer #(
  parameter int unsigned TABLE_AW     = 3,
  parameter int unsigned DWELL_W      = 24,
  parameter int unsigned TIMEOUT_CYC  = 15,
  parameter int unsigned CARRIER_ADDR = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [DWELL_W-1:0]  i_dwell,
  input  logic [TABLE_AW-1:0] i_last_idx,
  input  logic                i_err_clr,
  input  logic                i_tbl_we,
  input  logic [TABLE_AW-1:0] i_tbl_addr,
  input  logic [31:0]         i_tbl_data,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [1:0]          o_wb_addr,
  output logic [31:0]         o_wb_data,
  input  logic                i_wb_ack,
  input  logic                i_wb_stall,
  output logic                o_busy,
  output logic [TABLE_AW-1:0] o_hop_idx,
  output logic                o_hop_strobe,
  output logic                o_err
);

  localparam int unsigned DEPTH = 2 ** TABLE_AW;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_REQ      = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_DWELL    = 3'd4;

  logic [31:0]         hop_table [DEPTH];

  logic [2:0]          state, state_nxt;
  logic [TABLE_AW-1:0] idx, idx_nxt;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_nxt;
  logic [TO_W-1:0]     to_cnt, to_nxt;
  logic [TABLE_AW-1:0] hop_idx_nxt;
  logic                hop_strobe_nxt;
  logic                err_nxt;
  logic                cyc_nxt, stb_nxt, busy_nxt;
  logic                load_data;
  logic                hop_done;

  // Table write port; reads happen through the o_wb_data load below (read-first)
  always_ff @(posedge i_clk) begin
    if (i_tbl_we) begin
      hop_table[i_tbl_addr] <= i_tbl_data;
    end
  end

  assign o_wb_addr = 2'(CARRIER_ADDR);

  // State register and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      dwell_cnt    <= '0;
      to_cnt       <= '0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_data    <= '0;
      o_busy       <= 1'b0;
      o_hop_idx    <= '0;
      o_hop_strobe <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      dwell_cnt    <= dwell_nxt;
      to_cnt       <= to_nxt;
      o_wb_cyc     <= cyc_nxt;
      o_wb_stb     <= stb_nxt;
      o_wb_we      <= stb_nxt;
      o_busy       <= busy_nxt;
      o_hop_idx    <= hop_idx_nxt;
      o_hop_strobe <= hop_strobe_nxt;
      o_err        <= err_nxt;
      if (load_data) begin
        o_wb_data <= hop_table[idx];
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    dwell_nxt      = dwell_cnt;
    to_nxt         = to_cnt;
    hop_idx_nxt    = o_hop_idx;
    hop_strobe_nxt = 1'b0;
    err_nxt        = o_err & ~i_err_clr;
    load_data      = 1'b0;
    hop_done       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_enable && !o_err) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_data = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!i_wb_stall) begin
          if (i_wb_ack) begin
            hop_done = 1'b1;
          end else begin
            state_nxt = ST_WAIT_ACK;
            to_nxt    = '0;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (i_wb_ack) begin
          hop_done = 1'b1;
        end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      ST_DWELL: begin
        if (dwell_cnt <= DWELL_W'(1)) begin
          state_nxt = i_enable ? ST_LOAD : ST_IDLE;
        end else begin
          dwell_nxt = dwell_cnt - DWELL_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Acknowledged write: advance (wrapping on the live last index) and start dwelling
    if (hop_done) begin
      hop_strobe_nxt = 1'b1;
      hop_idx_nxt    = idx;
      idx_nxt        = (idx >= i_last_idx) ? '0 : idx + TABLE_AW'(1);
      dwell_nxt      = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
      state_nxt      = ST_DWELL;
    end

    cyc_nxt  = (state_nxt == ST_REQ) || (state_nxt == ST_WAIT_ACK);
    stb_nxt  = (state_nxt == ST_REQ);
    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule
